relm_adc_io: RTL and testbench
==============================

Name: relm_adc_io

Overview:
- Hardware SPI sequencer for the DE0-Nano ADC128S022. It replaces the CPU bit-banging of adc_cs_n/adc_sclk/adc_saddr.
- On the push side, the ReLM core writes a channel request. The block runs the 16-clock ADC frame(s) autonomously.
- On the pop side, the block presents the 12-bit result word, using the push/pop convention: bit WD = strobe on _d, bit WD = retry/not-ready on _q.
- Sits between the ReLM push/pop buses and the ADC pins at top level.

Parameters:
- WD, 32, data width; the bus is WD+1 bits with bit WD as the strobe/retry flag.
- DIV, 8, clk cycles per SCLK half-period (50 MHz / 16 = 3.125 MHz, within the ADC 3.2 MHz max); must be ≥ 4.

Ports:
- clk  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- push_d  input  WD+1  [WD] = request strobe, [2:0] = channel.
- push_retry  output  1  1 = request not accepted, CPU must repeat.
- pop_d  input  WD+1  [WD] = result-consume strobe.
- pop_q  output  WD+1  [WD] = not ready, [14:12] = channel, [11:0] = sample, other bits 0.
- adc_cs_n_out  output  1  ADC chip select, active low.
- adc_sclk_out  output  1  ADC serial clock, idles high.
- adc_saddr_out  output  1  ADC DIN (address).
- adc_sdat_in  input  1  ADC DOUT, asynchronous to clk.

Behaviour:
- Reset values:
  - adc_cs_n_out=1, adc_sclk_out=1, adc_saddr_out=0.
  - push_retry=0, pop_q=0 except pop_q[WD]=1.
  - cur_ch=0; addr_known=0, which forces a dummy frame on the first request.
- adc_sdat_in passes through a 2-FF synchroniser before sampling.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: push_retry=0. When push_d[WD]=1, capture req_ch=push_d[2:0], clear ready (pop_q[WD]<=1), go to SETUP.
  - Frame type on entry to SETUP: dummy if addr_known=0 or req_ch≠cur_ch; otherwise real.
  - SETUP: cs_n=0 for DIV cycles.
  - SHIFT: 16 SCLK periods, bit k=1..16. SCLK falls, stays low DIV cycles, rises, stays high DIV cycles.
  - saddr changes on the falling edge: req_ch[2] for k=3, req_ch[1] for k=4, req_ch[0] for k=5, 0 otherwise.
  - Sampling: the synchronised DOUT is shifted into a 16-bit register DIV−1 cycles after each rising edge. sample = sreg[11:0].
  - HOLD: SCLK high, cs_n low for DIV cycles, then cs_n=1. Set cur_ch=req_ch, addr_known=1.
  - GAP: cs_n high for DIV cycles. Next state:
    - after a dummy frame, SETUP (real frame);
    - after a real frame, latch pop_q={0, req_ch, sample} with pop_q[WD]=0, go to IDLE.
- push_retry=1 in every state except IDLE; a push while busy is ignored.
- Latency:
  - real frame: pop_q[WD] falls 35·DIV+1 cycles after the accepting edge (281 at DIV=8);
  - with dummy frame: +35·DIV.
- Pop:
  - pop_d[WD]=1 while ready → pop_q[WD]<=1 next cycle; data bits are held.
  - pop while not ready → no effect.
- Simultaneous push and pop in IDLE: push wins; ready is cleared and the conversion starts.
- An un-popped result is overwritten by the next request.
- Reset mid-frame: outputs go to reset values immediately and the frame is abandoned. addr_known=0, because the ADC address register state is unknown.

Optional Feature:
- Macro: RELM_ADC_AVG_EN.
- Defined:
  - each request runs 4 consecutive real frames after any dummy frame;
  - a 14-bit accumulator sums them and the result is sum[13:2], truncated;
  - latency is +3·35·DIV.
- Undefined: a single real frame per request, no accumulator logic.

Decomposition:
- Package relm_adc_pkg:
  - state enum;
  - FRAME_BITS=16, ADDR_FIRST_BIT=3, SAMPLE_W=12, CH_W=3;
  - the function giving saddr for bit k.
- One sub-module, relm_adc_sclk_gen:
  - DIV counter producing a half-period tick, fall/rise strobes and a sample strobe;
  - enabled by the FSM; restarts its phase on enable.

Test Plan:
1. Reset → cs_n=1, sclk=1, pop_q[WD]=1, push_retry=0. First push of ch 5 runs a dummy frame then a real frame: cs_n shows two low pulses, and saddr=1,0,1 at k=3..5 in both frames.
2. ADC model returns 0x0A5C on ch 5, ch 5 requested again → single frame; pop_q[14:0]={3'd5,12'hA5C}, pop_q[WD]=0 exactly 281 cycles after the accept (DIV=8).
3. Push during SHIFT → push_retry=1, no change to req_ch; after ready, pop strobe → pop_q[WD]=1 the next cycle, data held at 0x5A5C.
4. Ready result plus push of ch 2 and pop in the same cycle → conversion starts (dummy frame, since ch changes); old data does not reappear as ready.
5. Assert rst_in at k=4 of a frame → cs_n=1 within the same cycle (async); the next ch 5 request performs a dummy frame.
6. With RELM_ADC_AVG_EN, model returns 100,101,102,103 → result 101, and cs_n shows 4 real frames.

Source files
------------

// File: rtl/relm_adc_pkg.sv
// Shared types and constants for the ADC128S022 SPI sequencer (relm_adc_io).
package relm_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } adc_state_e;

    localparam int FRAME_BITS     = 16;
    localparam int ADDR_FIRST_BIT = 3;
    localparam int SAMPLE_W       = 12;
    localparam int CH_W           = 3;

    // DIN value for SCLK period k (1-based): channel MSB first at ADDR_FIRST_BIT, 0 elsewhere.
    function automatic logic saddr_for_bit(input logic [4:0] k, input logic [CH_W-1:0] ch);
        logic bit_v;
        bit_v = 1'b0;
        for (int i = 0; i < CH_W; i++) begin
            if (k == 5'(ADDR_FIRST_BIT + i)) bit_v = ch[CH_W-1-i];
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/relm_adc_io_sclk_gen.sv
// SCLK phase generator: DIV-cycle half periods with fall/rise/sample strobes.
// Held in phase zero while disabled, so every enable starts with a low half.
module relm_adc_sclk_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic fall,
    output logic rise,
    output logic smp
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic          phase_q;   // 0 = low half, 1 = high half
    logic          tick;

    assign tick = en && (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign fall = en && !phase_q && (cnt_q == '0);
    assign rise = en &&  phase_q && (cnt_q == '0);
    // Last cycle of the high half: DOUT has been stable since the previous fall.
    assign smp  = tick && phase_q;

endmodule

// File: rtl/relm_adc_io.sv
// ADC128S022 SPI sequencer between the ReLM push/pop buses and the ADC pins.
// Optional macro RELM_ADC_AVG_EN: average four real frames per request.
module relm_adc_io
    import relm_adc_pkg::*;
#(
    parameter int WD  = 32,
    parameter int DIV = 8
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic [WD:0]   push_d,
    output logic          push_retry,
    input  logic [WD:0]   pop_d,
    output logic [WD:0]   pop_q,
    output logic          adc_cs_n_out,
    output logic          adc_sclk_out,
    output logic          adc_saddr_out,
    input  logic          adc_sdat_in,
    output adc_state_e    dbg_state
);

    // Handshake: a push is taken when push_d[WD]=1 and push_retry=0 in that cycle;
    // a result is valid while pop_q[WD]=0 and is consumed by a cycle with pop_d[WD]=1.

    localparam int TW = $clog2(DIV);

    adc_state_e           state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [4:0]           bit_q, bit_d;
    logic [CH_W-1:0]      req_ch_q, req_ch_d;
    logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
    logic                 addr_known_q, addr_known_d;
    logic                 dummy_q, dummy_d;
    logic                 res_pend_q, res_pend_d;
    logic                 accept;
    logic                 tmr_last;
    logic                 hold_end;

    logic [FRAME_BITS-1:0] sreg_q;
    logic                  sdat_meta, sdat_sync;
    logic                  cs_n_q, sclk_q, saddr_q;
    logic                  fall, rise, smp;
    logic [SAMPLE_W-1:0]   result_w;

    assign tmr_last = (tmr_q == TW'(DIV - 1));
    assign hold_end = (state_q == ST_HOLD) && tmr_last;

`ifdef RELM_ADC_AVG_EN
    logic [1:0]  frm_q, frm_d;
    logic [13:0] acc_q;
    logic        unused_acc;
    assign result_w   = acc_q[13:2];
    assign unused_acc = ^acc_q[1:0];
`else
    assign result_w = sreg_q[SAMPLE_W-1:0];
`endif

    relm_adc_sclk_gen #(.DIV(DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst_in),
        .en   (state_q == ST_SHIFT),
        .fall (fall),
        .rise (rise),
        .smp  (smp)
    );

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q + 1'b1;
        bit_d        = bit_q;
        req_ch_d     = req_ch_q;
        cur_ch_d     = cur_ch_q;
        addr_known_d = addr_known_q;
        dummy_d      = dummy_q;
        res_pend_d   = 1'b0;
        accept       = 1'b0;
`ifdef RELM_ADC_AVG_EN
        frm_d        = frm_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (push_d[WD]) begin
                    accept   = 1'b1;
                    req_ch_d = push_d[CH_W-1:0];
                    // The ADC converts the channel addressed in the previous frame.
                    dummy_d  = !addr_known_q || (push_d[CH_W-1:0] != cur_ch_q);
                    state_d  = ST_SETUP;
`ifdef RELM_ADC_AVG_EN
                    frm_d    = 2'd0;
`endif
                end
            end
            ST_SETUP: begin
                if (tmr_last) begin
                    tmr_d   = '0;
                    bit_d   = 5'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                tmr_d = '0;
                if (smp) begin
                    if (bit_q == 5'(FRAME_BITS)) state_d = ST_HOLD;
                    else                         bit_d   = bit_q + 5'd1;
                end
            end
            ST_HOLD: begin
                if (tmr_last) begin
                    tmr_d        = '0;
                    cur_ch_d     = req_ch_q;
                    addr_known_d = 1'b1;
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_last) begin
                    tmr_d = '0;
                    if (dummy_q) begin
                        dummy_d = 1'b0;
                        state_d = ST_SETUP;
                    end
`ifdef RELM_ADC_AVG_EN
                    else if (frm_q != 2'd3) begin
                        frm_d   = frm_q + 2'd1;
                        state_d = ST_SETUP;
                    end
`endif
                    else begin
                        res_pend_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            bit_q        <= 5'd0;
            req_ch_q     <= '0;
            cur_ch_q     <= '0;
            addr_known_q <= 1'b0;
            dummy_q      <= 1'b0;
            res_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            bit_q        <= bit_d;
            req_ch_q     <= req_ch_d;
            cur_ch_q     <= cur_ch_d;
            addr_known_q <= addr_known_d;
            dummy_q      <= dummy_d;
            res_pend_q   <= res_pend_d;
        end
    end

`ifdef RELM_ADC_AVG_EN
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            frm_q <= 2'd0;
            acc_q <= 14'd0;
        end else begin
            frm_q <= frm_d;
            if (hold_end && !dummy_q)
                acc_q <= ((frm_q == 2'd0) ? 14'd0 : acc_q) + {2'b00, sreg_q[SAMPLE_W-1:0]};
        end
    end
`endif

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            sdat_meta <= 1'b0;
            sdat_sync <= 1'b0;
            sreg_q    <= '0;
        end else begin
            sdat_meta <= adc_sdat_in;
            sdat_sync <= sdat_meta;
            if (smp) sreg_q <= {sreg_q[FRAME_BITS-2:0], sdat_sync};
        end
    end

    // Pins are registered one cycle behind the state so they never glitch.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            saddr_q <= 1'b0;
        end else begin
            cs_n_q <= !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
            if (fall)                              sclk_q <= 1'b0;
            else if (rise || state_q != ST_SHIFT)  sclk_q <= 1'b1;
            if (fall) saddr_q <= saddr_for_bit(bit_q, req_ch_q);
        end
    end

    // A push in the same cycle as a pending result or a pop wins: ready stays low.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            pop_q <= {1'b1, {WD{1'b0}}};
        end else if (accept) begin
            pop_q[WD] <= 1'b1;
        end else if (res_pend_q) begin
            pop_q <= {1'b0, {(WD-CH_W-SAMPLE_W){1'b0}}, req_ch_q, result_w};
        end else if (pop_d[WD]) begin
            pop_q[WD] <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{push_d[WD-1:CH_W], pop_d[WD-1:0], sreg_q[FRAME_BITS-1:SAMPLE_W]};

    assign push_retry    = (state_q != ST_IDLE);
    assign adc_cs_n_out  = cs_n_q;
    assign adc_sclk_out  = sclk_q;
    assign adc_saddr_out = saddr_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_relm_adc_io.sv
// Directed + randomized bench for relm_adc_io with a pin-level ADC128S022 model.
module tb_relm_adc_io;
  import relm_adc_pkg::*;

  localparam int WD  = 32;
  localparam int DIV = 8;
`ifdef RELM_ADC_AVG_EN
  localparam int NREAL = 4;
`else
  localparam int NREAL = 1;
`endif
  localparam int FRAME_CYC = 35 * DIV;
  localparam int WAIT_MAX  = FRAME_CYC * (NREAL + 1) + 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [WD:0] push_d = '0;
  logic [WD:0] pop_d = '0;
  logic        push_retry;
  logic [WD:0] pop_q;
  logic        adc_cs_n_out, adc_sclk_out, adc_saddr_out;
  logic        adc_sdat_in = 1'b0;
  adc_state_e  dbg_state;

  relm_adc_io #(.WD(WD), .DIV(DIV)) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .push_d        (push_d),
    .push_retry    (push_retry),
    .pop_d         (pop_d),
    .pop_q         (pop_q),
    .adc_cs_n_out  (adc_cs_n_out),
    .adc_sclk_out  (adc_sclk_out),
    .adc_saddr_out (adc_saddr_out),
    .adc_sdat_in   (adc_sdat_in),
    .dbg_state     (dbg_state)
  );

  // ---------------- ADC pin model ----------------
  logic [11:0] adc_val [8];
  logic [11:0] ovr_q[$];
  logic [2:0]  frame_addr_q[$];
  int          adc_addr = 0;
  logic [2:0]  cap_addr = '0;
  logic [15:0] word = '0;
  int          kf = 0;
  int          cs_pulses = 0;

  always @(negedge adc_cs_n_out) begin
    kf = 0;
    cs_pulses++;
    if (ovr_q.size() > 0) word = {4'b0, ovr_q.pop_front()};
    else                  word = {4'b0, adc_val[adc_addr]};
  end
  always @(negedge adc_sclk_out) begin
    if (adc_cs_n_out === 1'b0 && kf < 16) begin
      kf++;
      adc_sdat_in = word[16-kf];
    end
  end
  always @(posedge adc_sclk_out) begin
    if (adc_cs_n_out === 1'b0 && kf >= 3 && kf <= 5) cap_addr[5-kf] = adc_saddr_out;
  end
  always @(posedge adc_cs_n_out) begin
    if (kf == 16) begin
      adc_addr = int'(cap_addr);
      frame_addr_q.push_back(cap_addr);
    end
    kf = 0;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [WD-1:0] exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic m_known = 1'b0;
  logic [2:0] m_cur = '0;
  logic [2:0] p_ch;
  int   p_frames, p_lat, p_pulses0, acc_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_request(input logic [2:0] ch, input logic with_pop, input logic [11:0] val);
    logic [WD-1:0] w;
    logic dummy;
    dummy    = !m_known || (ch != m_cur);
    p_ch     = ch;
    p_frames = (dummy ? 1 : 0) + NREAL;
    p_lat    = FRAME_CYC * p_frames + 1;
    w        = '0;
    w[14:12] = ch;
    w[11:0]  = val;
    exp_q.push_back(w);
    m_known  = 1'b1;
    m_cur    = ch;
    p_pulses0 = cs_pulses;
    frame_addr_q.delete();
    push_d = '0;
    push_d[WD] = 1'b1;
    push_d[2:0] = ch;
    pop_d[WD] = with_pop;
    @(posedge clk); #1;
    acc_cyc = cyc;
    push_d = '0;
    pop_d = '0;
    check("busy_retry", push_retry, 1);
    check("busy_not_ready", pop_q[WD], 1);
  endtask

  task automatic finish_request();
    int lat;
    for (int i = 0; i < WAIT_MAX && pop_q[WD] !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    lat = cyc - acc_cyc;
    check("latency", lat, p_lat);
    check("result", pop_q, {1'b0, exp_q.pop_front()});
    check("idle_retry", push_retry, 0);
    check("frames", cs_pulses - p_pulses0, p_frames);
    check("frame_addr_n", frame_addr_q.size(), p_frames);
    foreach (frame_addr_q[i]) check("frame_addr", frame_addr_q[i], p_ch);
  endtask

  task automatic run_request(input logic [2:0] ch, input logic [11:0] val);
    start_request(ch, 1'b0, val);
    finish_request();
  endtask

  task automatic do_pop(input logic [WD:0] held);
    pop_d[WD] = 1'b1;
    @(posedge clk); #1;
    pop_d = '0;
    check("pop_not_ready", pop_q[WD], 1);
    check("pop_data_held", pop_q[WD-1:0], held[WD-1:0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WD:0] held;
    logic [2:0]  ch;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom_range(0, 4095));
    adc_val[5] = 12'hA5C;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", adc_cs_n_out, 1);
    check("rst_sclk", adc_sclk_out, 1);
    check("rst_saddr", adc_saddr_out, 0);
    check("rst_retry", push_retry, 0);
    check("rst_pop_q", pop_q, {1'b1, {WD{1'b0}}});
    rst_in = 1'b0;
    @(posedge clk); #1;
    check("idle_state", dbg_state, ST_IDLE);

    // 1: first request forces a dummy frame
    run_request(3'd5, adc_val[5]);
    // 2: same channel again, single real frame
    run_request(3'd5, adc_val[5]);
    check("t2_word", pop_q[14:0], 15'h5A5C);

    // 3: push while shifting is ignored; pop then clears ready, data held
    start_request(3'd5, 1'b0, adc_val[5]);
    for (int i = 0; i < 4 * DIV && dbg_state != ST_SHIFT; i++) begin
      @(posedge clk); #1;
    end
    check("t3_in_shift", dbg_state, ST_SHIFT);
    push_d[WD] = 1'b1;
    push_d[2:0] = 3'd2;
    #1 check("t3_retry", push_retry, 1);
    @(posedge clk); #1;
    push_d = '0;
    finish_request();
    held = pop_q;
    do_pop(held);
    do_pop(held);

    // 4: ready result + push of ch 2 + pop together: push wins
    run_request(3'd5, adc_val[5]);
    start_request(3'd2, 1'b1, adc_val[2]);
    finish_request();

    // 5: reset mid-frame at k=4, then dummy frame again
    start_request(3'd2, 1'b0, adc_val[2]);
    for (int i = 0; i < 12 * DIV && kf != 4; i++) begin
      @(posedge clk); #1;
    end
    check("t5_at_k4", kf, 4);
    rst_in = 1'b1;
    #1;
    check("t5_cs_n", adc_cs_n_out, 1);
    check("t5_sclk", adc_sclk_out, 1);
    check("t5_pop_q", pop_q, {1'b1, {WD{1'b0}}});
    check("t5_retry", push_retry, 0);
    exp_q.delete();
    m_known = 1'b0;
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(posedge clk); #1;
    run_request(3'd5, adc_val[5]);

`ifdef RELM_ADC_AVG_EN
    // 6: four real frames averaged, truncated
    ovr_q = '{12'd100, 12'd101, 12'd102, 12'd103};
    run_request(3'd5, 12'd101);
`endif

    // Randomized requests
    for (int n = 0; n < 10; n++) begin
      ch = ($urandom_range(0, 2) == 0) ? m_cur : 3'($urandom_range(0, 7));
      adc_val[ch] = 12'($urandom_range(0, 4095));
      run_request(ch, adc_val[ch]);
      if ($urandom_range(0, 1) == 1) begin
        held = pop_q;
        do_pop(held);
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
